// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared encodings, field positions and FSM state for the decode stage
package decode_stage_pkg;
  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_ALU2 = 2'b01;
  localparam logic [1:0] CLS_MEM  = 2'b10;
  localparam logic [1:0] CLS_CTL  = 2'b11;
  localparam logic [4:0] OP_NOT   = 5'b10110;
  localparam logic [4:0] OP_SET_MAX = 5'd5;
  localparam logic [3:0] SUB_B    = 4'b0000;
  localparam logic [3:0] SUB_BC   = 4'b0001;
  localparam logic [3:0] SUB_BR   = 4'b0010;
  localparam int CLS_LSB  = 30;
  localparam int OP_LSB   = 25;
  localparam int SUB_LSB  = 25;
  localparam int HALT_BIT = 28;
  localparam int NOP_BIT  = 27;
  localparam int ST_BIT   = 25;
  localparam int DEST_LSB = 22;
  localparam int OP1_LSB  = 19;
  localparam int OP2_LSB  = 16;
  localparam int COND_LSB = 21;
  localparam int IMM_W    = 16;
  typedef enum logic [1:0] {RUN, STALL, HALTED} state_t;
  function automatic logic is_alu_op(input logic [4:0] op);
    return op inside {[5'd17:5'd21], [5'd25:5'd29]};
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write bits with writeback bypass on lookup
module reg_scoreboard #(
  parameter int ADDR_W = 3
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              drop_en,
  input  logic [ADDR_W-1:0] drop_addr,
  input  logic [ADDR_W-1:0] rd_a,
  input  logic [ADDR_W-1:0] rd_b,
  output logic              busy_a,
  output logic              busy_b
);
  localparam int N = 2**ADDR_W;
  logic [N-1:0] bits, eff, set_mask, drop_mask;
  assign eff       = clr_en ? bits & ~(N'(1) << clr_addr) : bits;
  assign set_mask  = set_en ? N'(1) << set_addr : '0;
  assign drop_mask = drop_en ? N'(1) << drop_addr : '0;
  assign busy_a    = eff[rd_a];
  assign busy_b    = eff[rd_b];
  // new reservations win over a same-cycle writeback to the same register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bits <= '0;
    else bits <= (eff & ~drop_mask) | set_mask;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode with scoreboard stall, flush and halt
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 3,
  parameter bit IMM_SEXT   = 1'b0
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            out_class,
  output logic                  out_alu_en,
  output logic                  out_set_flags,
  output logic [2:0]            out_alu_oc,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic [REG_ADDR_W-1:0] out_op1,
  output logic [REG_ADDR_W-1:0] out_op2,
  output logic [3:0]            out_cond,
  output logic [DATA_W-1:0]     out_imm,
  output logic                  out_we,
  output logic                  out_is_load,
  output logic                  out_is_store,
  output logic                  out_is_branch,
  output logic                  out_illegal,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic                  flush,
  output logic                  halted
);
  state_t state, state_nx;
  logic [31:0] r_instr;
  logic [1:0] cls;
  logic [4:0] op;
  logic [3:0] sub;
  logic is_nop, is_halt, is_br, legal, we, use_a, use_b;
  logic busy_a, busy_b, hazard, accept, emit;
  assign cls = in_instr[CLS_LSB +: 2];
  assign op  = in_instr[OP_LSB +: 5];
  assign sub = in_instr[SUB_LSB +: 4];
  // classify the incoming instruction and pick which operands it reads
  always_comb begin
    is_nop  = cls == CLS_CTL && in_instr[NOP_BIT];
    is_halt = cls == CLS_CTL && in_instr[HALT_BIT] && !in_instr[NOP_BIT];
    is_br   = cls == CLS_CTL && sub inside {SUB_B, SUB_BC, SUB_BR};
    legal   = cls == CLS_ALU  ? (op <= OP_SET_MAX || is_alu_op(op)) :
              cls == CLS_ALU2 ? (is_alu_op(op) || op == OP_NOT) :
              cls == CLS_MEM  ? 1'b1 : (is_br || is_nop || is_halt);
    we      = legal && (cls == CLS_ALU || cls == CLS_ALU2 || (cls == CLS_MEM && !in_instr[ST_BIT]));
    use_a   = legal && (cls != CLS_CTL || sub == SUB_BR);
    use_b   = legal && ((cls == CLS_ALU2 && op != OP_NOT) || (cls == CLS_MEM && in_instr[ST_BIT]));
  end
  assign hazard   = in_valid && ((use_a && busy_a) || (use_b && busy_b));
  assign halted   = state == HALTED;
  assign in_ready = (!out_valid || out_ready) && !hazard && !halted && !flush;
  assign accept   = in_valid && in_ready;
  assign emit     = accept && !is_nop && !is_halt;
  reg_scoreboard #(.ADDR_W(REG_ADDR_W)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (accept && we),
    .set_addr  (in_instr[DEST_LSB +: REG_ADDR_W]),
    .clr_en    (wb_valid),
    .clr_addr  (wb_addr),
    .drop_en   (flush && out_valid && !out_ready && out_we),
    .drop_addr (out_dest),
    .rd_a      (in_instr[OP1_LSB +: REG_ADDR_W]),
    .rd_b      (cls == CLS_MEM ? in_instr[DEST_LSB +: REG_ADDR_W] : in_instr[OP2_LSB +: REG_ADDR_W]),
    .busy_a    (busy_a),
    .busy_b    (busy_b)
  );
  // HALTED is sticky; STALL only reflects a waiting hazard
  always_comb begin
    state_nx = (halted || (accept && is_halt)) ? HALTED : (in_valid && hazard && !flush) ? STALL : RUN;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_nx;
  // output register: load on emit, otherwise drain on handoff, bubble or flush
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid     <= 1'b0;
      r_instr       <= '0;
      out_we        <= 1'b0;
      out_is_load   <= 1'b0;
      out_is_store  <= 1'b0;
      out_is_branch <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (emit) begin
      out_valid     <= 1'b1;
      r_instr       <= in_instr;
      out_we        <= we;
      out_is_load   <= cls == CLS_MEM && !in_instr[ST_BIT];
      out_is_store  <= cls == CLS_MEM && in_instr[ST_BIT];
      out_is_branch <= is_br;
      out_illegal   <= !legal;
    end else if (accept || flush || out_ready) out_valid <= 1'b0;
  assign out_class     = r_instr[CLS_LSB +: 2];
  assign out_alu_en    = r_instr[29];
  assign out_set_flags = r_instr[29] & r_instr[28];
  assign out_alu_oc    = r_instr[OP_LSB +: 3];
  assign out_dest      = r_instr[DEST_LSB +: REG_ADDR_W];
  assign out_op1       = r_instr[OP1_LSB +: REG_ADDR_W];
  assign out_op2       = r_instr[OP2_LSB +: REG_ADDR_W];
  assign out_cond      = r_instr[COND_LSB +: 4];
  assign out_imm       = {{(DATA_W-IMM_W){IMM_SEXT & r_instr[IMM_W-1]}}, r_instr[IMM_W-1:0]};
endmodule
